// File: rtl/cond_exec_stage.sv
// Conditional-execution stage: evaluates the instruction condition against the
// architectural flags, gates the write/PC controls, updates the flags and
// registers the result into a one-entry ready/valid output buffer.
module cond_exec_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   Cond,
  input  logic [3:0]   ALUFlags,
  input  logic [1:0]   FlagW,
  input  logic [N-1:0] ALUResult,
  input  logic [3:0]   Rd,
  input  logic         RegW,
  input  logic         MemW,
  input  logic         PCS,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_Result,
  output logic [3:0]   out_Rd,
  output logic         out_RegWrite,
  output logic         out_MemWrite,
  output logic         out_PCSrc,
  output logic [3:0]   Flags,
  output logic         CondEx,
  output logic [15:0]  skip_count
);

  // Condition decode against {N,Z,C,V}.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flg);
    logic n, z, c, v;
    logic res;
    n = flg[3];
    z = flg[2];
    c = flg[1];
    v = flg[0];
    case (cond)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = c;
      4'b0011: res = ~c;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = c & ~z;
      4'b1001: res = ~c | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  // Saturating increment for the skip counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] val);
    logic [15:0] res;
    if (val == 16'hFFFF) res = val;
    else                 res = val + 16'd1;
    return res;
  endfunction

  // Stage p0: combinational input side.
  logic cond_ex_p0;
  logic accept_p0;

  // Stage p1: registered output entry and architectural state.
  logic         vld_p1;
  logic [N-1:0] res_p1;
  logic [3:0]   rd_p1;
  logic         regw_p1;
  logic         memw_p1;
  logic         pcs_p1;
  logic [3:0]   flags_p1;
  logic [15:0]  skip_p1;

  // Condition uses the pre-update flags; accept is blocked by flush via in_ready.
  always_comb begin
    cond_ex_p0 = cond_eval(Cond, flags_p1);
    in_ready   = (~vld_p1 | out_ready) & ~flush;
    accept_p0  = in_valid & in_ready;
  end

  // Output-entry control: load on accept, drain on out_ready or flush, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      regw_p1 <= 1'b0;
      memw_p1 <= 1'b0;
      pcs_p1  <= 1'b0;
    end else if (accept_p0) begin
      vld_p1  <= 1'b1;
      regw_p1 <= RegW & cond_ex_p0;
      memw_p1 <= MemW & cond_ex_p0;
      pcs_p1  <= PCS  & cond_ex_p0;
    end else if (out_ready || flush) begin
      vld_p1  <= 1'b0;
    end
  end

  // Output-entry data: captured only on accept; cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p1 <= '0;
      rd_p1  <= '0;
    end else if (accept_p0) begin
      res_p1 <= ALUResult;
      rd_p1  <= Rd;
    end
  end

  // Architectural flags: per-half update only for an accepted, executed instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_p1 <= 4'b0000;
    end else if (accept_p0 && cond_ex_p0) begin
      if (FlagW[1]) flags_p1[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) flags_p1[1:0] <= ALUFlags[1:0];
    end
  end

  // Count accepted instructions whose condition failed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_p1 <= 16'd0;
    end else if (accept_p0 && !cond_ex_p0) begin
      skip_p1 <= sat_inc(skip_p1);
    end
  end

  assign CondEx       = cond_ex_p0;
  assign out_valid    = vld_p1;
  assign out_Result   = res_p1;
  assign out_Rd       = rd_p1;
  assign out_RegWrite = regw_p1;
  assign out_MemWrite = memw_p1;
  assign out_PCSrc    = pcs_p1;
  assign Flags        = flags_p1;
  assign skip_count   = skip_p1;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed bench for cond_exec_stage: condition-decode table plus hand-written
// sequences for reset, flag forwarding, stall, flush and counter saturation.
module tb_cond_exec_stage;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   Cond;
  logic [3:0]   ALUFlags;
  logic [1:0]   FlagW;
  logic [N-1:0] ALUResult;
  logic [3:0]   Rd;
  logic         RegW, MemW, PCS;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_Result;
  logic [3:0]   out_Rd;
  logic         out_RegWrite, out_MemWrite, out_PCSrc;
  logic [3:0]   Flags;
  logic         CondEx;
  logic [15:0]  skip_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  cond_exec_stage #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .ALUResult(ALUResult),
    .Rd(Rd), .RegW(RegW), .MemW(MemW), .PCS(PCS), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_Result(out_Result),
    .out_Rd(out_Rd), .out_RegWrite(out_RegWrite), .out_MemWrite(out_MemWrite),
    .out_PCSrc(out_PCSrc), .Flags(Flags), .CondEx(CondEx), .skip_count(skip_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       exp_cex;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; Cond = 4'b1110; ALUFlags = 0; FlagW = 0; ALUResult = 0;
    Rd = 0; RegW = 0; MemW = 0; PCS = 0; flush = 0; out_ready = 1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    in_valid = 1; RegW = 1; MemW = 1; PCS = 1; Cond = 4'b1110;
    FlagW = 2'b11; ALUFlags = 4'b1111; ALUResult = 32'hDEAD_BEEF; Rd = 4'hA;
    tick();
    tick();
    idle_inputs();
    rst_n = 1;
    #1;
  endtask

  // Load Flags through an always-executed instruction, then drain the entry.
  task automatic set_flags(input logic [3:0] f);
    in_valid = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f; out_ready = 1;
    tick();
    in_valid = 0; FlagW = 2'b00;
    tick();
  endtask

  logic [15:0] skip_before;

  initial begin
    vecs[0]  = '{4'b0100, 4'b0000, 1'b1};
    vecs[1]  = '{4'b0000, 4'b0000, 1'b0};
    vecs[2]  = '{4'b0000, 4'b0001, 1'b1};
    vecs[3]  = '{4'b0010, 4'b0010, 1'b1};
    vecs[4]  = '{4'b0010, 4'b0011, 1'b0};
    vecs[5]  = '{4'b1000, 4'b0100, 1'b1};
    vecs[6]  = '{4'b1000, 4'b0101, 1'b0};
    vecs[7]  = '{4'b0001, 4'b0110, 1'b1};
    vecs[8]  = '{4'b0001, 4'b0111, 1'b0};
    vecs[9]  = '{4'b0010, 4'b1000, 1'b1};
    vecs[10] = '{4'b0110, 4'b1000, 1'b0};
    vecs[11] = '{4'b0110, 4'b1001, 1'b1};
    vecs[12] = '{4'b1001, 4'b1010, 1'b1};
    vecs[13] = '{4'b1000, 4'b1010, 1'b0};
    vecs[14] = '{4'b1000, 4'b1101, 1'b1};
    vecs[15] = '{4'b1000, 4'b1011, 1'b1};
    vecs[16] = '{4'b0000, 4'b1100, 1'b1};
    vecs[17] = '{4'b0100, 4'b1100, 1'b0};
    vecs[18] = '{4'b0000, 4'b1101, 1'b0};
    vecs[19] = '{4'b0110, 4'b1111, 1'b1};

    idle_inputs();
    rst_n = 1;
    #2;
    // Asynchronous reset, checked before any clock edge sees it.
    rst_n = 0;
    in_valid = 1; RegW = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
    #1;
    chk("rst_flags", Flags, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ctrl", {out_RegWrite, out_MemWrite, out_PCSrc}, 0);
    chk("rst_result", out_Result, 0);
    chk("rst_rd", out_Rd, 0);
    chk("rst_skip", skip_count, 0);
    do_reset();
    chk("rst_discard_valid", out_valid, 0);
    chk("rst_discard_flags", Flags, 0);

    // Failing condition right after reset is skipped and counted.
    in_valid = 1; Cond = 4'b0000; RegW = 1; MemW = 1; PCS = 1;
    ALUResult = 32'h1234_5678; Rd = 4'h3;
    #1;
    chk("skip_condex", CondEx, 0);
    chk("skip_in_ready", in_ready, 1);
    tick();
    chk("skip_out_valid", out_valid, 1);
    chk("skip_regwrite", out_RegWrite, 0);
    chk("skip_memwrite", out_MemWrite, 0);
    chk("skip_pcsrc", out_PCSrc, 0);
    chk("skip_result", out_Result, 32'h1234_5678);
    chk("skip_rd", out_Rd, 3);
    chk("skip_count1", skip_count, 1);

    // Back-to-back: flags from the first accept seen by the next one.
    Cond = 4'b1110; ALUFlags = 4'b0100; FlagW = 2'b11; RegW = 1; MemW = 0; PCS = 1;
    ALUResult = 32'h0000_00AA; Rd = 4'h5;
    tick();
    chk("fwd_flags", Flags, 4'b0100);
    chk("fwd_regwrite", out_RegWrite, 1);
    chk("fwd_pcsrc", out_PCSrc, 1);
    chk("fwd_rd", out_Rd, 5);
    Cond = 4'b0000; FlagW = 2'b00;
    #1;
    chk("fwd_condex", CondEx, 1);
    tick();
    chk("fwd_skip_unchanged", skip_count, 1);
    in_valid = 0;
    tick();
    chk("drain_valid", out_valid, 0);

    // Partial flag writes: only the selected half updates.
    set_flags(4'b0000);
    in_valid = 1; Cond = 4'b1110; ALUFlags = 4'b1111; FlagW = 2'b01;
    tick();
    chk("flagw01", Flags, 4'b0011);
    FlagW = 2'b10; ALUFlags = 4'b1000;
    tick();
    chk("flagw10", Flags, 4'b1011);
    // Skipped instruction must not touch flags.
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0100;
    tick();
    chk("skip_no_flag", Flags, 4'b1011);
    in_valid = 0; FlagW = 2'b00;
    tick();

    // Condition decode table.
    for (int i = 0; i < 20; i++) begin
      set_flags(vecs[i].flags);
      Cond = vecs[i].cond;
      #1;
      chk($sformatf("decode_%0d_flags", i), Flags, {28'd0, vecs[i].flags});
      chk($sformatf("decode_%0d_cond%b", i, vecs[i].cond), CondEx, {31'd0, vecs[i].exp_cex});
    end

    // Stall: held entry blocks input for three cycles, then replaced same edge.
    set_flags(4'b0000);
    in_valid = 1; Cond = 4'b1110; FlagW = 2'b00; ALUResult = 32'h0000_0AAA; Rd = 4'h1;
    RegW = 1; MemW = 0; PCS = 0; out_ready = 0;
    tick();
    chk("stall_load_valid", out_valid, 1);
    chk("stall_load_result", out_Result, 32'h0000_0AAA);
    ALUResult = 32'h0000_0BBB; Rd = 4'h2; FlagW = 2'b11; ALUFlags = 4'b1111;
    RegW = 0; MemW = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall_%0d_in_ready", c), in_ready, 0);
      tick();
      chk($sformatf("stall_%0d_valid", c), out_valid, 1);
      chk($sformatf("stall_%0d_result", c), out_Result, 32'h0000_0AAA);
      chk($sformatf("stall_%0d_rd", c), out_Rd, 1);
      chk($sformatf("stall_%0d_regw", c), out_RegWrite, 1);
      chk($sformatf("stall_%0d_flags", c), Flags, 0);
    end
    out_ready = 1;
    #1;
    chk("unstall_in_ready", in_ready, 1);
    tick();
    chk("unstall_valid", out_valid, 1);
    chk("unstall_result", out_Result, 32'h0000_0BBB);
    chk("unstall_rd", out_Rd, 2);
    chk("unstall_memw", out_MemWrite, 1);
    chk("unstall_regw", out_RegWrite, 0);
    chk("unstall_flags", Flags, 4'b1111);

    // Flush wins over an offered instruction with a flag write.
    skip_before = skip_count;
    out_ready = 0; flush = 1; in_valid = 1; Cond = 4'b1110; FlagW = 2'b11;
    ALUFlags = 4'b0000; ALUResult = 32'h0000_0CCC; Rd = 4'h7;
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    chk("flush_valid", out_valid, 0);
    chk("flush_flags", Flags, 4'b1111);
    chk("flush_result_hold", out_Result, 32'h0000_0BBB);
    chk("flush_rd_hold", out_Rd, 2);
    Cond = 4'b0000;
    tick();
    chk("flush_skip_hold", skip_count, skip_before);
    flush = 0;

    // Reset asserted while an entry is stalled drops it immediately.
    in_valid = 1; Cond = 4'b1110; FlagW = 2'b00; ALUResult = 32'h0000_0DDD; Rd = 4'h9;
    out_ready = 0;
    tick();
    chk("midstall_valid", out_valid, 1);
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    chk("midstall_rst_valid", out_valid, 0);
    chk("midstall_rst_result", out_Result, 0);
    chk("midstall_rst_flags", Flags, 0);
    chk("midstall_rst_skip", skip_count, 0);
    do_reset();

    // Skip counter saturation.
    in_valid = 1; Cond = 4'b0000; out_ready = 1; RegW = 0;
    repeat (65534) tick();
    chk("sat_fffe", skip_count, 16'hFFFE);
    tick();
    chk("sat_ffff", skip_count, 16'hFFFF);
    tick();
    chk("sat_hold", skip_count, 16'hFFFF);
    in_valid = 0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cond_exec_stage.md
COND_EXEC_STAGE -- requirements
Module: cond_exec_stage

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning the datapath width of the ALU result.
REQ-002 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  is the reset: asynchronous assert, active-low.
REQ-004 Port in_valid  input  1  means an executed instruction is presented.
REQ-005 Port in_ready  output  1  means the stage can accept that instruction this cycle.
REQ-006 Port Cond  input  4  is the instruction condition field.
REQ-007 Port ALUFlags  input  4  is the ALU flags {N,Z,C,V} (bit3..bit0).
REQ-008 Port FlagW  input  2  is the flag write request: bit1 updates N,Z; bit0 updates C,V.
REQ-009 Port ALUResult  input  N  is the ALU result.
REQ-010 Port Rd  input  4  is the destination register index.
REQ-011 Ports RegW, MemW and PCS are each input, 1 bit: the ungated register-write, memory-write and PC-source requests.
REQ-012 Port flush  input  1  means squash the instruction in flight.
REQ-013 Port out_valid  output  1  means the registered instruction is valid.
REQ-014 Port out_ready  input  1  means the downstream stage accepts the output.
REQ-015 Ports out_Result (N bits) and out_Rd (4 bits) are outputs carrying the registered result and destination.
REQ-016 Ports out_RegWrite, out_MemWrite and out_PCSrc are each output, 1 bit: the registered, condition-gated write and PC-source controls.
REQ-017 Port Flags  output  4  is the architectural {N,Z,C,V} flag register.
REQ-018 Port CondEx  output  1  is the combinational condition result for the current input.
REQ-019 Port skip_count  output  16  counts instructions squashed by their condition.

Function
REQ-020 CondEx SHALL be evaluated against Flags, i.e. the pre-update flags, using this decode:
- 0000 Z; 0001 ~Z; 0010 C; 0011 ~C
- 0100 N; 0101 ~N; 0110 V; 0111 ~V
- 1000 C&~Z; 1001 ~C|Z
- 1010 N==V; 1011 N!=V
- 1100 ~Z&(N==V); 1101 Z|(N!=V)
- 1110 1; 1111 1
REQ-021 in_ready SHALL equal (~out_valid | out_ready) & ~flush.
REQ-022 An instruction is accepted when in_valid & in_ready.
REQ-023 On accept, the output registers SHALL capture:
- ALUResult and Rd
- RegW&CondEx, MemW&CondEx, PCS&CondEx
- out_valid set to 1
REQ-024 With no accept and out_ready=1, out_valid SHALL clear to 0; with no accept and out_ready=0, all output registers SHALL hold.
REQ-025 On accept with CondEx=1, Flags[3:2] SHALL load ALUFlags[3:2] if FlagW[1]=1, and Flags[1:0] SHALL load ALUFlags[1:0] if FlagW[0]=1; otherwise Flags SHALL hold.
REQ-026 Flags SHALL never change without an accept, so a back-to-back instruction sees the updated flags in the next cycle.
REQ-027 On accept with CondEx=0, skip_count SHALL increment by 1, saturating at 16'hFFFF.
REQ-028 flush=1 SHALL take priority over all other activity:
- out_valid cleared next cycle
- no accept, no Flags update, no skip_count change
- out_Result and out_Rd hold their values
REQ-029 Accept latency SHALL be one cycle: input accepted at edge k appears on the outputs after edge k.
REQ-030 Simultaneous accept and out_ready=1 SHALL replace the output entry with no bubble.

Reset
REQ-031 While rst_n=0, regardless of clk:
- Flags=0000
- out_valid=0, out_RegWrite=0, out_MemWrite=0, out_PCSrc=0
- out_Result=0, out_Rd=0
- skip_count=0
REQ-032 An instruction presented during reset SHALL be discarded.
REQ-033 A reset asserted mid-stall SHALL drop the held entry.

Verification
REQ-034 The bench SHALL cover: after reset, Cond=0000, in_valid=1, RegW=1 -> CondEx=0, out_RegWrite=0, skip_count=1.
REQ-035 The bench SHALL cover: accept ALUFlags=0100, FlagW=11, Cond=1110; next cycle Cond=0000 -> Flags=0100, CondEx=1.
REQ-036 The bench SHALL cover: Flags=1001, Cond=1010 -> CondEx=1; Flags=1000, Cond=1010 -> CondEx=0; Flags=1000, Cond=1101 -> CondEx=1.
REQ-037 The bench SHALL cover: out_valid=1 and out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs and Flags hold; then out_ready=1 -> new entry loaded the same edge.
REQ-038 The bench SHALL cover: flush=1 with in_valid=1 and FlagW=11 -> out_valid=0 next cycle, Flags unchanged.
REQ-039 The bench SHALL cover: preload skip_count to FFFF via 65535 skipped instructions, then one more skipped instruction -> skip_count stays FFFF.
